crossover_child_assembler: RTL and testbench

- Consumes the per-gene 2-bit select stream produced by the single-point crossover select generator.
- Reads each gene from the parent-1 or parent-2 genome RAM and writes it, in order, into the child genome RAM.
- Sits directly downstream of the select generator and upstream of the child genome memory / mutation stage.
- Reports the child gene count and a one-cycle done pulse.

---
 rtl/neat_xover_pkg.sv | 29 ++
 rtl/gene_src_mux.sv | 33 +++
 rtl/crossover_child_assembler.sv | 206 ++++++++++++++++++++
 tb/tb_crossover_child_assembler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/neat_xover_pkg.sv
// Shared definitions for the crossover datapath: select-stream codes
// (common with the select generator), assembler state encoding and
// default widths.
package neat_xover_pkg;

  // Select stream codes
  localparam logic [1:0] SEL_P1   = 2'b10;
  localparam logic [1:0] SEL_P2   = 2'b11;
  localparam logic [1:0] SEL_END  = 2'b01;
  localparam logic [1:0] SEL_IDLE = 2'b00;

  // Default widths
  localparam int DEF_GENE_W = 32;
  localparam int DEF_ADDR_W = 8;

  // Assembler states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A select code carries a gene when its upper bit is set (10 or 11)
  function automatic logic is_gene(input logic [1:0] s);
    return s[1];
  endfunction

endpackage

// File: rtl/gene_src_mux.sv
// Registered stage-2 data mux: captures the tagged parent's read data
// into the child write-data register when a stage-2 gene is present.
module gene_src_mux #(
  parameter int GENE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              tag,
  input  logic [GENE_W-1:0] p1_rdata,
  input  logic [GENE_W-1:0] p2_rdata,
  output logic [GENE_W-1:0] wdata
);

  logic [GENE_W-1:0] mux_word;

  // Per-bit source selection: tag=1 picks parent 2
  generate
    for (genvar gi = 0; gi < GENE_W; gi++) begin : g_bit
      assign mux_word[gi] = tag ? p2_rdata[gi] : p1_rdata[gi];
    end
  endgenerate

  // Hold the last written word; update only when a gene retires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdata <= '0;
    end else if (load) begin
      wdata <= mux_word;
    end
  end

endmodule

// File: rtl/crossover_child_assembler.sv
// Child genome assembler: turns the per-gene select stream into parent
// RAM reads and in-order child RAM writes, then reports size and done.
// Optional macro CHILD_SRC_COUNT_EN adds per-parent gene counters.
module crossover_child_assembler
  import neat_xover_pkg::*;
#(
  parameter int GENE_W = DEF_GENE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        sel,
  output logic [ADDR_W-1:0] p1_addr,
  input  logic [GENE_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] p2_addr,
  input  logic [GENE_W-1:0] p2_rdata,
  output logic              child_we,
  output logic [ADDR_W-1:0] child_addr,
  output logic [GENE_W-1:0] child_wdata,
  output logic [ADDR_W-1:0] child_size,
  output logic              busy,
  output logic              done,
  output logic              ovf
`ifdef CHILD_SRC_COUNT_EN
  ,
  output logic [ADDR_W-1:0] p1_gene_cnt,
  output logic [ADDR_W-1:0] p2_gene_cnt
`endif
);

  localparam logic [ADDR_W-1:0] IDX_MAX = {ADDR_W{1'b1}};

  state_t            state_reg, state_next;
  logic              drain_cnt_reg;
  logic [ADDR_W-1:0] idx_reg;

  // Pipeline: stage 1 = address issued, stage 2 = RAM data available
  logic              s1_valid_reg, s2_valid_reg;
  logic              s1_tag_reg, s2_tag_reg;
  logic [ADDR_W-1:0] s1_idx_reg, s2_idx_reg;

  // FSM decode strobes
  logic start_run;
  logic accept;
  logic set_ovf;
  logic finish;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-cycle strobes
  always_comb begin
    state_next = state_reg;
    start_run  = 1'b0;
    accept     = 1'b0;
    set_ovf    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          start_run  = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (is_gene(sel)) begin
          if (idx_reg == IDX_MAX) begin
            // No address left for this gene: drop it and wind down
            set_ovf    = 1'b1;
            state_next = ST_DRAIN;
          end else begin
            accept = 1'b1;
          end
        end else if (sel == SEL_END) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Two-cycle drain timer so the last accepted gene retires before done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt_reg <= 1'b0;
    end else begin
      drain_cnt_reg <= (state_reg == ST_DRAIN) ? ~drain_cnt_reg : 1'b0;
    end
  end

  // Gene index, parent read addresses and stage-1 capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg      <= '0;
      p1_addr      <= '0;
      p2_addr      <= '0;
      s1_valid_reg <= 1'b0;
      s1_tag_reg   <= 1'b0;
      s1_idx_reg   <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (start_run) begin
        idx_reg <= '0;
      end else if (accept) begin
        p1_addr    <= idx_reg;
        p2_addr    <= idx_reg;
        s1_tag_reg <= sel[0];
        s1_idx_reg <= idx_reg;
        idx_reg    <= idx_reg + 1'b1;
      end
    end
  end

  // Stage-2 capture and child write strobe/address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_reg <= 1'b0;
      s2_tag_reg   <= 1'b0;
      s2_idx_reg   <= '0;
      child_we     <= 1'b0;
      child_addr   <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_tag_reg <= s1_tag_reg;
        s2_idx_reg <= s1_idx_reg;
      end
      child_we <= s2_valid_reg;
      if (s2_valid_reg) begin
        child_addr <= s2_idx_reg;
      end
    end
  end

  gene_src_mux #(
    .GENE_W (GENE_W)
  ) u_mux (
    .clk      (clk),
    .rst      (rst),
    .load     (s2_valid_reg),
    .tag      (s2_tag_reg),
    .p1_rdata (p1_rdata),
    .p2_rdata (p2_rdata),
    .wdata    (child_wdata)
  );

  // Completion status: size, overflow flag and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      child_size <= '0;
      ovf        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= finish;
      if (start_run) begin
        child_size <= '0;
        ovf        <= 1'b0;
      end else begin
        if (set_ovf) begin
          ovf <= 1'b1;
        end
        if (finish) begin
          child_size <= idx_reg;
        end
      end
    end
  end

  assign busy = (state_reg != ST_IDLE);

`ifdef CHILD_SRC_COUNT_EN
  // Per-parent accepted-gene counters; only move while genes are accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_gene_cnt <= '0;
      p2_gene_cnt <= '0;
    end else if (start_run) begin
      p1_gene_cnt <= '0;
      p2_gene_cnt <= '0;
    end else if (accept) begin
      if (sel[0]) begin
        p2_gene_cnt <= p2_gene_cnt + 1'b1;
      end else begin
        p1_gene_cnt <= p1_gene_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crossover_child_assembler.sv
// Bench for crossover_child_assembler: directed and random select
// streams checked against a list-based model of the expected writes.
module tb_crossover_child_assembler;

  localparam int GW = 32;
  localparam int AW = 8;
  localparam int MAXC = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    sel;
  logic [AW-1:0] p1_addr, p2_addr;
  logic [GW-1:0] p1_rdata, p2_rdata;
  logic          child_we;
  logic [AW-1:0] child_addr;
  logic [GW-1:0] child_wdata;
  logic [AW-1:0] child_size;
  logic          busy, done, ovf;
`ifdef CHILD_SRC_COUNT_EN
  logic [AW-1:0] p1_gene_cnt, p2_gene_cnt;
`endif

  crossover_child_assembler #(.GENE_W(GW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sel         (sel),
    .p1_addr     (p1_addr),
    .p1_rdata    (p1_rdata),
    .p2_addr     (p2_addr),
    .p2_rdata    (p2_rdata),
    .child_we    (child_we),
    .child_addr  (child_addr),
    .child_wdata (child_wdata),
    .child_size  (child_size),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf)
`ifdef CHILD_SRC_COUNT_EN
    ,
    .p1_gene_cnt (p1_gene_cnt),
    .p2_gene_cnt (p2_gene_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Parent RAMs with one-cycle registered read
  logic [GW-1:0] p1_mem [0:255];
  logic [GW-1:0] p2_mem [0:255];
  always @(posedge clk) begin
    p1_rdata <= p1_mem[p1_addr];
    p2_rdata <= p2_mem[p2_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [1:0] stim[$];

  // Expected per-cycle write activity (cycle 0 = start edge)
  bit            exp_we   [0:MAXC-1];
  logic [AW-1:0] exp_addr [0:MAXC-1];
  logic [GW-1:0] exp_data [0:MAXC-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we"}, child_we, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".ovf"}, ovf, 0);
    chk({tag, ".size"}, child_size, 0);
    chk({tag, ".p1a"}, p1_addr, 0);
    chk({tag, ".p2a"}, p2_addr, 0);
    chk({tag, ".caddr"}, child_addr, 0);
    chk({tag, ".cdata"}, child_wdata, 0);
`ifdef CHILD_SRC_COUNT_EN
    chk({tag, ".n1"}, p1_gene_cnt, 0);
    chk({tag, ".n2"}, p2_gene_cnt, 0);
`endif
  endtask

  // Model the stream from its rules, then drive it and compare every cycle
  task automatic run_stream(input string name);
    int idx, kend, done_c, n1, n2;
    bit ov;
    logic [GW-1:0] d;
    for (int i = 0; i < MAXC; i++) exp_we[i] = 1'b0;
    idx = 0; kend = -1; ov = 1'b0; n1 = 0; n2 = 0;
    for (int k = 0; k < stim.size(); k++) begin
      if (stim[k] == 2'b01) begin kend = k; break; end
      if (stim[k][1]) begin
        if (idx == 255) begin ov = 1'b1; kend = k; break; end
        d = stim[k][0] ? p2_mem[idx] : p1_mem[idx];
        exp_we[k+3]   = 1'b1;
        exp_addr[k+3] = AW'(idx);
        exp_data[k+3] = d;
        if (stim[k][0]) n2++; else n1++;
        idx++;
      end
    end
    if (kend < 0) begin
      $display("FAIL %s: stimulus has no terminator", name);
      $fatal(1);
    end
    done_c = kend + 4;

    @(negedge clk);
    start = 1'b1;
    sel   = 2'($urandom_range(0, 3));
    @(negedge clk);
    start = 1'b0;
    chk({name, ".busy0"}, busy, 1);
    chk({name, ".size0"}, child_size, 0);
    for (int c = 1; c <= done_c; c++) begin
      sel   = (c - 1 < stim.size()) ? stim[c-1] : 2'($urandom_range(0, 3));
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("%s.we@%0d", name, c), child_we, exp_we[c]);
      if (exp_we[c] && child_we) begin
        chk($sformatf("%s.addr@%0d", name, c), child_addr, exp_addr[c]);
        chk($sformatf("%s.data@%0d", name, c), child_wdata, exp_data[c]);
      end
      chk($sformatf("%s.done@%0d", name, c), done, (c == done_c));
      chk($sformatf("%s.busy@%0d", name, c), busy, (c < done_c));
    end
    start = 1'b0;
    sel   = 2'b00;
    chk({name, ".size"}, child_size, idx);
    chk({name, ".ovf"}, ovf, ov);
`ifdef CHILD_SRC_COUNT_EN
    chk({name, ".n1"}, p1_gene_cnt, n1);
    chk({name, ".n2"}, p2_gene_cnt, n2);
`endif
    $display("stream %s: genes=%0d ovf=%0d done_cycle=%0d", name, idx, ov, done_c);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      p1_mem[i] = 32'h100 + i;
      p2_mem[i] = 32'h200 + i;
    end
    rst = 1'b0; start = 1'b0; sel = 2'b00;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // Crossover at position 3
    stim = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
    run_stream("xover3");

    // Crossover at position 0
    stim = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
    run_stream("xover0");

    // Bubbles in the stream
    stim = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
    run_stream("bubble");

    // Empty child
    stim = '{2'b01};
    run_stream("empty");

    // Reset after the second accepted gene of a six-gene stream
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sel = 2'b10;
    @(negedge clk);
    sel = 2'b11;
    @(negedge clk);
    sel = 2'b10;
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst.we@%0d", c), child_we, 0);
      chk($sformatf("midrst.busy@%0d", c), busy, 0);
    end
    rst = 1'b1;
    sel = 2'b00;
    stim = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01};
    run_stream("after_rst");

    // Overflow: 256 parent-1 genes
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(2'b10);
    stim.push_back(2'b01);
    run_stream("ovf");

    // Random streams with random parent contents
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) begin
        p1_mem[i] = $urandom;
        p2_mem[i] = $urandom;
      end
      stim.delete();
      for (int i = 0; i < int'($urandom_range(0, 15)); i++) begin
        case ($urandom_range(0, 2))
          0:       stim.push_back(2'b10);
          1:       stim.push_back(2'b11);
          default: stim.push_back(2'b00);
        endcase
      end
      stim.push_back(2'b01);
      for (int i = 0; i < 4; i++) stim.push_back(2'($urandom_range(0, 3)));
      run_stream($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
